// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

    localparam int WORD_W          = 16;
    localparam int TIMER_W         = 4;
    localparam int DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        F_WAIT = 2'b01,
        D_WAIT = 2'b10
    } arb_state_t;

    // True while an access is outstanding and the response is being awaited.
    function automatic logic is_wait(input arb_state_t s);
        return (s == F_WAIT) || (s == D_WAIT);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter, bundled with the
// arbiter (slave) and environment (master) views.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              f_req;
    logic [WORD_W-1:0] f_addr;
    logic              f_flush;
    logic              f_done;
    logic [WORD_W-1:0] f_rdata;
    logic              f_stall;

    logic              d_req;
    logic              d_wr;
    logic [WORD_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              d_done;
    logic [WORD_W-1:0] d_rdata;
    logic              d_stall;

    logic              mem_ready;
    logic              mem_en;
    logic              mem_wr;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_done;
    logic [WORD_W-1:0] mem_rdata;

    logic              err;

    modport slave (
        input  f_req, f_addr, f_flush,
        output f_done, f_rdata, f_stall,
        input  d_req, d_wr, d_addr, d_wdata,
        output d_done, d_rdata, d_stall,
        input  mem_ready, mem_done, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output err
    );

    modport master (
        output f_req, f_addr, f_flush,
        input  f_done, f_rdata, f_stall,
        output d_req, d_wr, d_addr, d_wdata,
        input  d_done, d_rdata, d_stall,
        output mem_ready, mem_done, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  err
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Response-wait counter: cleared on issue, counts wait cycles, and flags the
// cycle in which the count would reach the limit.
module mem_arb_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_next;

    // One extra bit keeps the compare honest when the limit is the maximum value.
    assign w_next    = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign o_expired = i_enable && (w_next == {1'b0, i_limit});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_next[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: fetch and data stages share one memory, data has
// absolute priority, one access outstanding, sticky err on timeout/protocol faults.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_flush_pend;
    logic              w_flush_pend_next;
    logic              r_err;
    logic              w_err_set;
    logic              r_d_wr;
    logic              w_issue;
    logic              w_issue_data;
    logic              w_timer_en;
    logic              w_expired;
    logic              w_mem_en;
    logic              w_mem_wr;
    logic [WORD_W-1:0] w_mem_addr;
    logic [WORD_W-1:0] w_mem_wdata;
    logic              w_f_done;
    logic              w_d_done;

    assign w_timer_en = is_wait(r_state) && !bus.mem_done;

    mem_arb_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_issue),
        .i_enable  (w_timer_en),
        .i_limit   (LIMIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_flush_pend <= w_flush_pend_next;
        end
    end

    // The store/load direction is latched at issue so a mid-access change can be flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err  <= 1'b0;
            r_d_wr <= 1'b0;
        end else begin
            r_err <= r_err | w_err_set;
            if (w_issue_data) begin
                r_d_wr <= bus.d_wr;
            end
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_flush_pend_next = r_flush_pend;
        w_err_set         = 1'b0;
        w_issue           = 1'b0;
        w_issue_data      = 1'b0;
        w_mem_en          = 1'b0;
        w_mem_wr          = 1'b0;
        w_mem_addr        = '0;
        w_mem_wdata       = '0;
        w_f_done          = 1'b0;
        w_d_done          = 1'b0;

        case (r_state)
            IDLE: begin
                w_flush_pend_next = 1'b0;
                w_err_set         = bus.mem_done;
                // The memory stage holds the older instruction, so it always wins.
                if (bus.d_req && bus.mem_ready) begin
                    w_issue      = 1'b1;
                    w_issue_data = 1'b1;
                    w_mem_en     = 1'b1;
                    w_mem_wr     = bus.d_wr;
                    w_mem_addr   = bus.d_addr;
                    w_mem_wdata  = bus.d_wdata;
                    w_next_state = D_WAIT;
                end else if (bus.f_req && !bus.f_flush && bus.mem_ready) begin
                    w_issue      = 1'b1;
                    w_mem_en     = 1'b1;
                    w_mem_addr   = bus.f_addr;
                    w_next_state = F_WAIT;
                end
            end

            F_WAIT: begin
                if (bus.mem_done) begin
                    w_f_done          = !(r_flush_pend || bus.f_flush);
                    w_flush_pend_next = 1'b0;
                    w_next_state      = IDLE;
                end else if (w_expired) begin
                    w_err_set         = 1'b1;
                    w_flush_pend_next = 1'b0;
                    w_next_state      = IDLE;
                end else if (bus.f_flush) begin
                    w_flush_pend_next = 1'b1;
                end
            end

            D_WAIT: begin
                w_err_set = bus.d_req && (bus.d_wr != r_d_wr);
                if (bus.mem_done) begin
                    w_d_done     = 1'b1;
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_err_set    = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_flush_pend_next = 1'b0;
                w_next_state      = IDLE;
            end
        endcase
    end

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign bus.f_done  = w_f_done;
    assign bus.f_rdata = w_f_done ? bus.mem_rdata : '0;
    assign bus.f_stall = bus.f_req & ~w_f_done;

    assign bus.d_done  = w_d_done;
    assign bus.d_rdata = w_d_done ? bus.mem_rdata : '0;
    assign bus.d_stall = bus.d_req & ~w_d_done;

    assign bus.err = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(
        .TIMEOUT (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus values presented for the coming cycle.
    logic        s_rst;
    logic        s_f_req, s_f_flush, s_d_req, s_d_wr, s_mem_ready, s_mem_done;
    logic [15:0] s_f_addr, s_d_addr, s_d_wdata, s_mem_rdata;

    // Transaction-level model: one optional outstanding access.
    bit m_busy, m_isData, m_dropped, m_err, m_dWr;
    int m_waited;

    // Outputs the model requires in the current cycle.
    logic        e_mem_en, e_mem_wr, e_f_done, e_d_done;
    logic [15:0] e_mem_addr, e_mem_wdata, e_f_rdata, e_d_rdata;

    int memLat = 0;

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        m_busy    = 0;
        m_isData  = 0;
        m_dropped = 0;
        m_err     = 0;
        m_dWr     = 0;
        m_waited  = 0;
    endtask

    task automatic clearStim();
        s_f_req     = 0;
        s_f_flush   = 0;
        s_d_req     = 0;
        s_d_wr      = 0;
        s_mem_ready = 1;
        s_mem_done  = 0;
        s_f_addr    = '0;
        s_d_addr    = '0;
        s_d_wdata   = '0;
        s_mem_rdata = '0;
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
        rst           = s_rst;
        bus.f_req     = s_f_req;
        bus.f_addr    = s_f_addr;
        bus.f_flush   = s_f_flush;
        bus.d_req     = s_d_req;
        bus.d_wr      = s_d_wr;
        bus.d_addr    = s_d_addr;
        bus.d_wdata   = s_d_wdata;
        bus.mem_ready = s_mem_ready;
        bus.mem_done  = s_mem_done;
        bus.mem_rdata = s_mem_rdata;
    endtask

    task automatic checkOutput();
        bit issue;
        bit errNow;
        #3;
        if (s_rst) resetModel();
        issue       = 0;
        errNow      = 0;
        e_mem_en    = 0;
        e_mem_wr    = 0;
        e_mem_addr  = '0;
        e_mem_wdata = '0;
        e_f_done    = 0;
        e_f_rdata   = '0;
        e_d_done    = 0;
        e_d_rdata   = '0;

        if (!m_busy) begin
            if (s_mem_done) errNow = 1;
            if (s_mem_ready && (s_d_req || (s_f_req && !s_f_flush))) begin
                issue    = 1;
                e_mem_en = 1;
                if (s_d_req) begin
                    e_mem_wr    = s_d_wr;
                    e_mem_addr  = s_d_addr;
                    e_mem_wdata = s_d_wdata;
                end else begin
                    e_mem_addr = s_f_addr;
                end
            end
        end else begin
            if (s_mem_done) begin
                if (m_isData) begin
                    e_d_done  = 1;
                    e_d_rdata = s_mem_rdata;
                end else if (!(m_dropped || s_f_flush)) begin
                    e_f_done  = 1;
                    e_f_rdata = s_mem_rdata;
                end
            end else if (m_waited + 1 == TO) begin
                errNow = 1;
            end
            if (m_isData && s_d_req && (s_d_wr != m_dWr)) errNow = 1;
        end

        checkVal("mem_en",    {15'd0, bus.mem_en},  {15'd0, e_mem_en});
        checkVal("mem_wr",    {15'd0, bus.mem_wr},  {15'd0, e_mem_wr});
        checkVal("mem_addr",  bus.mem_addr,          e_mem_addr);
        checkVal("mem_wdata", bus.mem_wdata,         e_mem_wdata);
        checkVal("f_done",    {15'd0, bus.f_done},  {15'd0, e_f_done});
        checkVal("f_rdata",   bus.f_rdata,           e_f_rdata);
        checkVal("f_stall",   {15'd0, bus.f_stall}, {15'd0, s_f_req && !e_f_done});
        checkVal("d_done",    {15'd0, bus.d_done},  {15'd0, e_d_done});
        checkVal("d_rdata",   bus.d_rdata,           e_d_rdata);
        checkVal("d_stall",   {15'd0, bus.d_stall}, {15'd0, s_d_req && !e_d_done});
        checkVal("err",       {15'd0, bus.err},     {15'd0, m_err});

        if (s_rst) begin
            resetModel();
        end else begin
            m_err = m_err | errNow;
            if (issue) begin
                m_busy    = 1;
                m_isData  = s_d_req;
                m_dWr     = s_d_wr;
                m_dropped = 0;
                m_waited  = 0;
            end else if (m_busy) begin
                if (s_mem_done || (m_waited + 1 == TO)) begin
                    m_busy = 0;
                end else begin
                    m_waited++;
                    if (!m_isData && s_f_flush) m_dropped = 1;
                end
            end
        end
    endtask

    task automatic stepCycle();
        applyStimulus();
        checkOutput();
    endtask

    task automatic resetDut();
        clearStim();
        s_rst = 1;
        stepCycle();
        stepCycle();
        s_rst  = 0;
        memLat = 0;
        stepCycle();
    endtask

    task automatic randomNext();
        if (e_mem_en) memLat = $urandom_range(1, 4);
        s_mem_done  = 0;
        s_mem_rdata = 16'($urandom);
        if (memLat > 0) begin
            memLat--;
            if (memLat == 0) s_mem_done = 1;
        end

        if (e_f_done || s_f_flush) begin
            s_f_req  = ($urandom_range(0, 3) != 0);
            s_f_addr = 16'($urandom);
        end else if (!s_f_req) begin
            s_f_req  = ($urandom_range(0, 1) != 0);
            s_f_addr = 16'($urandom);
        end
        s_f_flush = ($urandom_range(0, 9) == 0);

        if (e_d_done || !s_d_req) begin
            s_d_req   = ($urandom_range(0, 2) == 0);
            s_d_wr    = ($urandom_range(0, 1) != 0);
            s_d_addr  = 16'($urandom);
            s_d_wdata = 16'($urandom);
        end
        s_mem_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        bus.f_req = 0; bus.f_addr = '0; bus.f_flush = 0;
        bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ready = 0; bus.mem_done = 0; bus.mem_rdata = '0;
        resetModel();
        resetDut();

        // Single fetch, response two cycles after issue.
        s_f_req = 1; s_f_addr = 16'h0010;
        stepCycle();
        checkVal("t1_issue", {15'd0, bus.mem_en}, 16'd1);
        checkVal("t1_addr", bus.mem_addr, 16'h0010);
        checkVal("t1_stall0", {15'd0, bus.f_stall}, 16'd1);
        stepCycle();
        checkVal("t1_noissue", {15'd0, bus.mem_en}, 16'd0);
        checkVal("t1_stall1", {15'd0, bus.f_stall}, 16'd1);
        s_mem_done = 1; s_mem_rdata = 16'hC0DE;
        stepCycle();
        checkVal("t1_done", {15'd0, bus.f_done}, 16'd1);
        checkVal("t1_rdata", bus.f_rdata, 16'hC0DE);
        checkVal("t1_stall2", {15'd0, bus.f_stall}, 16'd0);
        s_f_req = 0; s_mem_done = 0;
        stepCycle();

        // Fetch and store together: store first, fetch right after d_done.
        s_f_req = 1; s_f_addr = 16'h0020;
        s_d_req = 1; s_d_wr = 1; s_d_addr = 16'h0200; s_d_wdata = 16'hBEEF;
        stepCycle();
        checkVal("t2_wr", {15'd0, bus.mem_wr}, 16'd1);
        checkVal("t2_addr", bus.mem_addr, 16'h0200);
        checkVal("t2_wdata", bus.mem_wdata, 16'hBEEF);
        s_mem_done = 1;
        stepCycle();
        checkVal("t2_ddone", {15'd0, bus.d_done}, 16'd1);
        checkVal("t2_fstall", {15'd0, bus.f_stall}, 16'd1);
        s_d_req = 0; s_mem_done = 0;
        stepCycle();
        checkVal("t2_fissue", {15'd0, bus.mem_en}, 16'd1);
        checkVal("t2_faddr", bus.mem_addr, 16'h0020);
        s_mem_done = 1; s_mem_rdata = 16'h1111;
        stepCycle();
        s_f_req = 0; s_mem_done = 0;
        stepCycle();

        // Flush while a fetch is in flight drops its response.
        s_f_req = 1; s_f_addr = 16'h0030;
        stepCycle();
        s_f_flush = 1; s_f_addr = 16'h0040;
        stepCycle();
        s_f_flush = 0; s_mem_done = 1; s_mem_rdata = 16'hDEAD;
        stepCycle();
        checkVal("t3_dropped", {15'd0, bus.f_done}, 16'd0);
        s_mem_done = 0;
        stepCycle();
        checkVal("t3_reissue", bus.mem_addr, 16'h0040);
        s_mem_done = 1; s_mem_rdata = 16'h1234;
        stepCycle();
        checkVal("t3_rdata", bus.f_rdata, 16'h1234);
        s_f_req = 0; s_mem_done = 0;
        stepCycle();

        // Flush in IDLE blocks that cycle's fetch issue only.
        s_f_req = 1; s_f_flush = 1; s_f_addr = 16'h0050;
        stepCycle();
        checkVal("t3_idleflush", {15'd0, bus.mem_en}, 16'd0);
        s_f_flush = 0;
        stepCycle();
        checkVal("t3_afterflush", bus.mem_addr, 16'h0050);
        s_mem_done = 1;
        stepCycle();
        s_f_req = 0; s_mem_done = 0;
        stepCycle();

        // Memory not ready: the grant retries until it is.
        s_d_req = 1; s_d_wr = 0; s_d_addr = 16'h0300; s_mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkVal("t4_wait", {15'd0, bus.mem_en}, 16'd0);
        end
        s_mem_ready = 1;
        stepCycle();
        checkVal("t4_issue", {15'd0, bus.mem_en}, 16'd1);
        s_mem_done = 1; s_mem_rdata = 16'h5A5A;
        stepCycle();
        checkVal("t4_rdata", bus.d_rdata, 16'h5A5A);
        s_d_req = 0; s_mem_done = 0;
        stepCycle();

        // Randomized traffic against the model.
        clearStim();
        memLat = 0;
        for (int i = 0; i < 3000; i++) begin
            stepCycle();
            randomNext();
        end
        resetDut();

        // Timeout: no response for TO wait cycles.
        s_d_req = 1; s_d_wr = 0; s_d_addr = 16'h0400;
        stepCycle();
        for (int i = 0; i < TO; i++) begin
            stepCycle();
            checkVal("t5_err_low", {15'd0, bus.err}, 16'd0);
        end
        stepCycle();
        checkVal("t5_err_high", {15'd0, bus.err}, 16'd1);
        checkVal("t5_back_idle", {15'd0, bus.mem_en}, 16'd1);
        stepCycle();
        stepCycle();
        checkVal("t5_sticky", {15'd0, bus.err}, 16'd1);
        #1;
        s_rst = 1;
        rst   = 1;
        #1;
        checkVal("t5_async_rst", {15'd0, bus.err}, 16'd0);
        resetModel();
        resetDut();

        // Spurious response in IDLE.
        s_mem_done = 1; s_mem_rdata = 16'h7777;
        stepCycle();
        checkVal("t6_no_fdone", {15'd0, bus.f_done}, 16'd0);
        checkVal("t6_no_ddone", {15'd0, bus.d_done}, 16'd0);
        s_mem_done = 0;
        stepCycle();
        checkVal("t6_err", {15'd0, bus.err}, 16'd1);
        resetDut();

        // Store/load direction flipping mid-access.
        s_d_req = 1; s_d_wr = 1; s_d_addr = 16'h0500; s_d_wdata = 16'h0F0F;
        stepCycle();
        s_d_wr = 0;
        stepCycle();
        s_mem_done = 1;
        stepCycle();
        checkVal("t7_err", {15'd0, bus.err}, 16'd1);
        s_d_req = 0; s_mem_done = 0;
        stepCycle();
        resetDut();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        s_rst = 1;
        clearStim();
    end

endmodule
